// File: rtl/controle_envase.sv
// Bottling line controller: conveyor, fill valve and sealer sequencing
// with cork stock, dozen counter, and latched alarm cause.
//
// Ports:
//   clk, reset (async, active-low)
//   start, garrafa, nivel, pos_ved : run request / bottle, level, seal position
//   done_ved, alarme_ved           : sealer completion / sealer fault
//   carga, rearme                  : cork-load pulse / alarm acknowledge
//   motor, ev, req_ved, alarme     : conveyor, valve, seal request, alarm
//   cod_alarme                     : 01 fill timeout, 10 sealer fault, 11 seal timeout
//   duzia, cont_garrafas           : dozen pulse, bottles in current crate
//   estoque, sem_rolha             : corks in stock, stock empty
module controle_envase #(
  parameter int T_ENCHE    = 16,
  parameter int T_VEDA     = 8,
  parameter int ROLHAS_MAX = 20,
  parameter int RECARGA    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       garrafa,
  input  logic       nivel,
  input  logic       pos_ved,
  input  logic       done_ved,
  input  logic       alarme_ved,
  input  logic       carga,
  input  logic       rearme,
  output logic       motor,
  output logic       ev,
  output logic       req_ved,
  output logic       alarme,
  output logic [1:0] cod_alarme,
  output logic       duzia,
  output logic [3:0] cont_garrafas,
  output logic [4:0] estoque,
  output logic       sem_rolha
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRANSPORTA = 3'd1,
    ENCHE      = 3'd2,
    LEVA_VED   = 3'd3,
    VEDA       = 3'd4,
    ALARME     = 3'd5
  } state_t;

  localparam int TMAX = (T_ENCHE > T_VEDA) ? T_ENCHE : T_VEDA;
  localparam int TW   = $clog2(TMAX + 1);

  state_t         r_state;
  logic [TW-1:0]  r_timer;
  logic [3:0]     r_cont;
  logic [4:0]     r_estoque;
  logic [1:0]     r_cod;
  logic           r_duzia;

  logic           w_seal;
  logic           w_fill_to;
  logic           w_seal_to;
  logic [6:0]     w_sum;
  logic [4:0]     w_est_next;

  // alarme_ved outranks done_ved, so a seal only counts without a fault
  assign w_seal    = (r_state == VEDA) && !alarme_ved && done_ved;
  assign w_fill_to = (r_timer == TW'(T_ENCHE - 1));
  assign w_seal_to = (r_timer == TW'(T_VEDA - 1));

  // decrement and reload combine before saturating
  always_comb begin
    w_sum = {2'b00, r_estoque};
    if (w_seal && (r_estoque != 5'd0))
      w_sum = w_sum - 7'd1;
    if (carga)
      w_sum = w_sum + 7'(RECARGA);
    if (w_sum > 7'(ROLHAS_MAX))
      w_est_next = 5'(ROLHAS_MAX);
    else
      w_est_next = w_sum[4:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_cont    <= 4'd0;
      r_estoque <= 5'd0;
      r_cod     <= 2'b00;
      r_duzia   <= 1'b0;
    end else begin
      r_estoque <= w_est_next;
      r_duzia   <= 1'b0;
      if ((r_state == ENCHE) || (r_state == VEDA))
        r_timer <= r_timer + 1'b1;
      else
        r_timer <= '0;
      if (w_seal) begin
        if (r_cont == 4'd11) begin
          r_cont  <= 4'd0;
          r_duzia <= 1'b1;
        end else begin
          r_cont <= r_cont + 4'd1;
        end
      end
      unique case (r_state)
        IDLE: begin
          if (start && (r_estoque != 5'd0))
            r_state <= TRANSPORTA;
        end
        TRANSPORTA: begin
          if (garrafa) begin
            r_state <= ENCHE;
            r_timer <= '0;
          end
        end
        ENCHE: begin
          if (nivel) begin
            r_state <= LEVA_VED;
          end else if (w_fill_to) begin
            r_state <= ALARME;
            r_cod   <= 2'b01;
          end
        end
        LEVA_VED: begin
          if (pos_ved) begin
            r_state <= VEDA;
            r_timer <= '0;
          end
        end
        VEDA: begin
          if (alarme_ved) begin
            r_state <= ALARME;
            r_cod   <= 2'b10;
          end else if (done_ved) begin
            if (start && (w_est_next != 5'd0))
              r_state <= TRANSPORTA;
            else
              r_state <= IDLE;
          end else if (w_seal_to) begin
            r_state <= ALARME;
            r_cod   <= 2'b11;
          end
        end
        ALARME: begin
          if (rearme) begin
            r_state <= IDLE;
            r_cod   <= 2'b00;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cod   <= 2'b00;
        end
      endcase
    end
  end

  assign motor         = (r_state == TRANSPORTA) || (r_state == LEVA_VED);
  assign ev            = (r_state == ENCHE);
  assign req_ved       = (r_state == VEDA);
  assign alarme        = (r_state == ALARME);
  assign cod_alarme    = r_cod;
  assign duzia         = r_duzia;
  assign cont_garrafas = r_cont;
  assign estoque       = r_estoque;
  assign sem_rolha     = (r_estoque == 5'd0);

endmodule

// File: tb/tb_controle_envase.sv
// Bench for controle_envase: randomized bottle runs checked
// against a stock/crate model derived from the operating rules.
module tb_controle_envase;

  localparam int RC = 10;
  localparam int MX = 20;

  logic       clk = 1'b0;
  logic       reset, start, garrafa, nivel, pos_ved;
  logic       done_ved, alarme_ved, carga, rearme;
  logic       motor, ev, req_ved, alarme, duzia, sem_rolha;
  logic [1:0] cod_alarme;
  logic [3:0] cont_garrafas;
  logic [4:0] estoque;

  int n_cmp = 0;
  int n_err = 0;
  int m_stock = 0;
  int m_count = 0;

  controle_envase dut (
    .clk(clk), .reset(reset), .start(start), .garrafa(garrafa),
    .nivel(nivel), .pos_ved(pos_ved), .done_ved(done_ved),
    .alarme_ved(alarme_ved), .carga(carga), .rearme(rearme),
    .motor(motor), .ev(ev), .req_ved(req_ved), .alarme(alarme),
    .cod_alarme(cod_alarme), .duzia(duzia),
    .cont_garrafas(cont_garrafas), .estoque(estoque),
    .sem_rolha(sem_rolha)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > MX) ? MX : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {garrafa, nivel, pos_ved, done_ved, alarme_ved, rearme, carga} = '0;
  endtask

  // bits: garrafa nivel pos_ved done_ved alarme_ved rearme
  task automatic noise(input logic [5:0] mask);
    logic [5:0] r;
    r = 6'($urandom) & mask;
    {garrafa, nivel, pos_ved, done_ved, alarme_ved, rearme} = r;
  endtask

  task automatic load();
    clr();
    carga = 1'b1;
    tick();
    carga = 1'b0;
    m_stock = sat(m_stock + RC);
    n_cmp++;
    if (estoque !== 5'(m_stock)) begin
      n_err++;
      $display("FAIL load_stock got %0d want %0d", estoque, m_stock);
    end
  endtask

  task automatic go();
    clr();
    start = 1'b1;
    tick();
    n_cmp++;
    if (motor !== (m_stock > 0)) begin
      n_err++;
      $display("FAIL go_motor got %0b want %0b", motor, m_stock > 0);
    end
  endtask

  task automatic to_veda();
    clr();
    garrafa = 1'b1;
    tick();
    clr();
    n_cmp++;
    if ({motor, ev, req_ved, alarme} !== 4'b0100) begin
      n_err++;
      $display("FAIL enter_fill got %b want 0100", {motor, ev, req_ved, alarme});
    end
    nivel = 1'b1;
    tick();
    clr();
    n_cmp++;
    if ({motor, ev, req_ved, alarme} !== 4'b1000) begin
      n_err++;
      $display("FAIL enter_carry got %b want 1000", {motor, ev, req_ved, alarme});
    end
    pos_ved = 1'b1;
    tick();
    clr();
    n_cmp++;
    if ({motor, ev, req_ved, alarme} !== 4'b0010) begin
      n_err++;
      $display("FAIL enter_seal got %b want 0010", {motor, ev, req_ved, alarme});
    end
  endtask

  // one complete bottle starting from the conveyor state
  task automatic bottle(input bit reload, input bit seal_carga,
                        input bit keep_start);
    int  w;
    bit  wrap;
    if (reload) load();
    w = $urandom_range(0, 4);
    repeat (w) begin
      noise(6'b011111);
      tick();
      n_cmp++;
      if ({motor, ev, req_ved, alarme} !== 4'b1000) begin
        n_err++;
        $display("FAIL wait_bottle got %b want 1000", {motor, ev, req_ved, alarme});
      end
    end
    clr();
    garrafa = 1'b1;
    tick();
    w = $urandom_range(0, 14);
    repeat (w) begin
      noise(6'b101111);
      tick();
      n_cmp++;
      if ({motor, ev, req_ved, alarme} !== 4'b0100) begin
        n_err++;
        $display("FAIL filling got %b want 0100", {motor, ev, req_ved, alarme});
      end
    end
    clr();
    nivel = 1'b1;
    tick();
    w = $urandom_range(0, 4);
    repeat (w) begin
      noise(6'b110111);
      tick();
      n_cmp++;
      if ({motor, ev, req_ved, alarme} !== 4'b1000) begin
        n_err++;
        $display("FAIL carrying got %b want 1000", {motor, ev, req_ved, alarme});
      end
    end
    clr();
    pos_ved = 1'b1;
    tick();
    if (!keep_start) start = 1'b0;
    w = $urandom_range(0, 6);
    repeat (w) begin
      noise(6'b111001);
      tick();
      n_cmp++;
      if ({motor, ev, req_ved, alarme} !== 4'b0010) begin
        n_err++;
        $display("FAIL sealing got %b want 0010", {motor, ev, req_ved, alarme});
      end
    end
    clr();
    done_ved = 1'b1;
    carga = seal_carga;
    tick();
    clr();
    wrap = (m_count == 11);
    m_count = (m_count + 1) % 12;
    m_stock = sat(m_stock - 1 + (seal_carga ? RC : 0));
    n_cmp++;
    if (cont_garrafas !== 4'(m_count) || estoque !== 5'(m_stock)) begin
      n_err++;
      $display("FAIL seal_counts got %0d/%0d want %0d/%0d",
               cont_garrafas, estoque, m_count, m_stock);
    end
    n_cmp++;
    if (duzia !== wrap) begin
      n_err++;
      $display("FAIL seal_duzia got %0b want %0b", duzia, wrap);
    end
    n_cmp++;
    if (motor !== (start && m_stock > 0) || sem_rolha !== (m_stock == 0)) begin
      n_err++;
      $display("FAIL seal_next got motor=%0b sem=%0b want %0b/%0b",
               motor, sem_rolha, start && m_stock > 0, m_stock == 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    clr();
    #12;
    n_cmp++;
    if ({motor, ev, req_ved, alarme, duzia, sem_rolha} !== 6'b000001 ||
        cod_alarme !== 2'b00 || cont_garrafas !== 4'd0 || estoque !== 5'd0) begin
      n_err++;
      $display("FAIL reset_vals got %b cod=%b cnt=%0d est=%0d want 000001/00/0/0",
               {motor, ev, req_ved, alarme, duzia, sem_rolha},
               cod_alarme, cont_garrafas, estoque);
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (motor !== 1'b0) begin
      n_err++;
      $display("FAIL empty_start got %0b want 0", motor);
    end
    start = 1'b0;
  endtask

  task automatic test_basic();
    load();
    go();
    bottle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_dozen();
    for (int i = 0; i < 11; i++)
      bottle(m_stock < 3, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (duzia !== 1'b0 || cont_garrafas !== 4'd0) begin
      n_err++;
      $display("FAIL duzia_after got %0b/%0d want 0/0", duzia, cont_garrafas);
    end
  endtask

  task automatic test_fill_timeout();
    clr();
    garrafa = 1'b1;
    tick();
    repeat (15) begin
      noise(6'b101111);
      tick();
      n_cmp++;
      if ({ev, alarme} !== 2'b10) begin
        n_err++;
        $display("FAIL fill_wait got %b want 10", {ev, alarme});
      end
    end
    clr();
    tick();
    n_cmp++;
    if ({motor, ev, alarme} !== 3'b001 || cod_alarme !== 2'b01) begin
      n_err++;
      $display("FAIL fill_to got %b cod=%b want 001/01", {motor, ev, alarme}, cod_alarme);
    end
    repeat ($urandom_range(2, 5)) begin
      noise(6'b111110);
      tick();
      n_cmp++;
      if (alarme !== 1'b1 || cod_alarme !== 2'b01) begin
        n_err++;
        $display("FAIL alarm_hold got %0b/%b want 1/01", alarme, cod_alarme);
      end
    end
    load();
    start = 1'b0;
    clr();
    rearme = 1'b1;
    tick();
    clr();
    n_cmp++;
    if ({motor, alarme} !== 2'b00 || cod_alarme !== 2'b00) begin
      n_err++;
      $display("FAIL rearme got %b cod=%b want 00/00", {motor, alarme}, cod_alarme);
    end
  endtask

  task automatic test_seal_fault();
    go();
    to_veda();
    alarme_ved = 1'b1;
    done_ved = 1'b1;
    tick();
    clr();
    n_cmp++;
    if (alarme !== 1'b1 || cod_alarme !== 2'b10 ||
        estoque !== 5'(m_stock) || cont_garrafas !== 4'(m_count)) begin
      n_err++;
      $display("FAIL seal_fault got %0b/%b/%0d/%0d want 1/10/%0d/%0d",
               alarme, cod_alarme, estoque, cont_garrafas, m_stock, m_count);
    end
    start = 1'b0;
    rearme = 1'b1;
    tick();
    clr();
    go();
    to_veda();
    repeat (7) begin
      noise(6'b111001);
      tick();
      n_cmp++;
      if ({req_ved, alarme} !== 2'b10) begin
        n_err++;
        $display("FAIL seal_wait got %b want 10", {req_ved, alarme});
      end
    end
    clr();
    tick();
    n_cmp++;
    if ({req_ved, alarme} !== 2'b01 || cod_alarme !== 2'b11) begin
      n_err++;
      $display("FAIL seal_to got %b cod=%b want 01/11", {req_ved, alarme}, cod_alarme);
    end
    start = 1'b0;
    rearme = 1'b1;
    tick();
    clr();
  endtask

  task automatic test_last_cork();
    go();
    while (m_stock > 1) bottle(1'b0, 1'b0, 1'b1);
    bottle(1'b0, 1'b0, 1'b1);
    start = 1'b1;
    repeat (3) begin
      tick();
      n_cmp++;
      if ({motor, ev, req_ved, alarme} !== 4'b0000 || sem_rolha !== 1'b1) begin
        n_err++;
        $display("FAIL empty_idle got %b sem=%0b want 0000/1",
                 {motor, ev, req_ved, alarme}, sem_rolha);
      end
    end
    start = 1'b0;
    repeat (3) load();
  endtask

  task automatic test_carga_seal();
    go();
    bottle(1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (motor !== 1'b0 || estoque !== 5'(m_stock)) begin
      n_err++;
      $display("FAIL stop_idle got %0b/%0d want 0/%0d", motor, estoque, m_stock);
    end
  endtask

  task automatic test_async_reset();
    go();
    to_veda();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({motor, ev, req_ved, alarme, duzia, sem_rolha} !== 6'b000001 ||
        cont_garrafas !== 4'd0 || estoque !== 5'd0 || cod_alarme !== 2'b00) begin
      n_err++;
      $display("FAIL async_reset got %b cnt=%0d est=%0d want 000001/0/0",
               {motor, ev, req_ved, alarme, duzia, sem_rolha},
               cont_garrafas, estoque);
    end
    @(negedge clk);
    reset = 1'b1;
    m_stock = 0;
    m_count = 0;
    start = 1'b1;
    tick();
    n_cmp++;
    if ({motor, req_ved} !== 2'b00) begin
      n_err++;
      $display("FAIL post_reset got %b want 00", {motor, req_ved});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dozen();
    test_fill_timeout();
    test_seal_fault();
    test_last_cork();
    test_carga_seal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
